// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the ID/EXE hazard sequencer: opcodes, forwarding selects
// and sequencer states.
package pipe_hazard_ctrl_pkg;

    localparam int         DEF_ASIZE = 5;

    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MBUSY = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side bundle: ID-stage instruction fields in, pipe enables and operand
// selects out.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE
);
    logic             id_valid;
    logic [2:0]       id_opcode;
    logic [ASIZE-1:0] id_raddr1;
    logic [ASIZE-1:0] id_raddr2;
    logic             id_use_rs2;
    logic [ASIZE-1:0] id_waddr;
    logic             id_wen;

    logic             ifid_hold;
    logic             idexe_hold;
    logic             idexe_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             exe_busy;
    logic [15:0]      stall_cnt;

    modport master (
        output id_valid, id_opcode, id_raddr1, id_raddr2, id_use_rs2, id_waddr, id_wen,
        input  ifid_hold, idexe_hold, idexe_bubble, fwd_a, fwd_b, exe_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_raddr1, id_raddr2, id_use_rs2, id_waddr, id_wen,
        output ifid_hold, idexe_hold, idexe_bubble, fwd_a, fwd_b, exe_busy, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select and load-use detection against the EXE and MEM
// scoreboard entries.
module fwd_select
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic [ASIZE-1:0] src,
    input  logic             use_src,
    input  logic             exe_v,
    input  logic [ASIZE-1:0] exe_waddr,
    input  logic             exe_ld,
    input  logic             mem_v,
    input  logic [ASIZE-1:0] mem_waddr,
    output logic [1:0]       sel,
    output logic             load_hazard
);

    logic src_live;
    logic hit_exe;
    logic hit_mem;

    always_comb begin
        src_live    = use_src && (src != '0);
        hit_exe     = src_live && exe_v && (exe_waddr == src);
        hit_mem     = src_live && mem_v && (mem_waddr == src);
        load_hazard = hit_exe && exe_ld;
        sel         = FWD_RF;
        if (hit_exe && !exe_ld) begin
            sel = FWD_EXM;
        end else if (hit_mem) begin
            sel = FWD_MWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EXE sequencer: destination scoreboard, registered forwarding selects,
// load-use bubble insertion and multi-cycle multiply hold.
//
//   state    | meaning
//   ST_RUN   | normal issue, one instruction per cycle
//   ST_MBUSY | multiply in EXE; issue slot reopens when cnt reaches 1
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int         ASIZE   = DEF_ASIZE,
    parameter logic [2:0] LOAD_OP = OP_LOAD,
    parameter logic [2:0] MUL_OP  = OP_MUL,
    parameter int         MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef struct packed {
        logic             v;
        logic [ASIZE-1:0] waddr;
        logic             ld;
    } exe_ent_t;

    typedef struct packed {
        logic             v;
        logic [ASIZE-1:0] waddr;
    } mem_ent_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    exe_ent_t    exe_q, exe_d;
    mem_ent_t    mem_q, mem_d;
    logic [1:0]  fwd_a_q, fwd_a_d;
    logic [1:0]  fwd_b_q, fwd_b_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [1:0]  sel_a, sel_b;
    logic        haz_a, haz_b;
    logic        issue_slot;
    logic        load_use;
    logic        ifid_hold, idexe_hold, idexe_bubble, exe_busy;

    fwd_select #(.ASIZE(ASIZE)) u_fwd_a (
        .src         (bus.id_raddr1),
        .use_src     (1'b1),
        .exe_v       (exe_q.v),
        .exe_waddr   (exe_q.waddr),
        .exe_ld      (exe_q.ld),
        .mem_v       (mem_q.v),
        .mem_waddr   (mem_q.waddr),
        .sel         (sel_a),
        .load_hazard (haz_a)
    );

    fwd_select #(.ASIZE(ASIZE)) u_fwd_b (
        .src         (bus.id_raddr2),
        .use_src     (bus.id_use_rs2),
        .exe_v       (exe_q.v),
        .exe_waddr   (exe_q.waddr),
        .exe_ld      (exe_q.ld),
        .mem_v       (mem_q.v),
        .mem_waddr   (mem_q.waddr),
        .sel         (sel_b),
        .load_hazard (haz_b)
    );

    // The final multiply cycle doubles as an issue slot so back-to-back work loses nothing.
    assign issue_slot = (state_q == ST_RUN) || (cnt_q == CW'(1));
    assign load_use   = bus.id_valid && issue_slot && (haz_a || haz_b);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exe_d        = exe_q;
        mem_d        = '{v: exe_q.v, waddr: exe_q.waddr};
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        ifid_hold    = 1'b0;
        idexe_hold   = 1'b0;
        idexe_bubble = 1'b0;
        exe_busy     = 1'b0;

        if (issue_slot) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            if (!bus.id_valid) begin
                idexe_bubble = 1'b1;
                exe_d        = '0;
            end else if (load_use) begin
                ifid_hold    = 1'b1;
                idexe_bubble = 1'b1;
                exe_d        = '0;
            end else begin
                exe_d.v     = bus.id_wen && (bus.id_waddr != '0);
                exe_d.waddr = bus.id_waddr;
                exe_d.ld    = (bus.id_opcode == LOAD_OP);
                fwd_a_d     = sel_a;
                fwd_b_d     = sel_b;
                if (bus.id_opcode == MUL_OP) begin
                    state_d = ST_MBUSY;
                    cnt_d   = CW'(MUL_LAT);
                end
            end
        end else begin
            // Multiply still busy: EXE and selects frozen, MEM drains as bubbles.
            ifid_hold  = 1'b1;
            idexe_hold = 1'b1;
            exe_busy   = 1'b1;
            mem_d      = '0;
            cnt_d      = cnt_q - CW'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (ifid_hold && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            exe_q       <= '0;
            mem_q       <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ifid_hold    = ifid_hold;
    assign bus.idexe_hold   = idexe_hold;
    assign bus.idexe_bubble = idexe_bubble;
    assign bus.exe_busy     = exe_busy;
    assign bus.fwd_a        = fwd_a_q;
    assign bus.fwd_b        = fwd_b_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed cycle-by-cycle vectors for pipe_hazard_ctrl plus a reset-during-multiply sequence.
module tb_pipe_hazard_ctrl;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] ADDI = 3'b001;
    localparam logic [2:0] LD   = 3'b110;
    localparam logic [2:0] MUL  = 3'b111;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pipe_hazard_ctrl_if #(.ASIZE(5)) bus ();

    pipe_hazard_ctrl #(
        .ASIZE   (5),
        .LOAD_OP (3'b110),
        .MUL_OP  (3'b111),
        .MUL_LAT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [2:0] op;
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic       use2;
        logic [4:0] wa;
        logic       wen;
        logic       e_ifid;
        logic       e_idexe;
        logic       e_bub;
        logic       e_busy;
        logic       chk_fwd;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        int         e_stall;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic vld, input logic [2:0] op, input logic [4:0] ra1,
                                input logic [4:0] ra2, input logic use2, input logic [4:0] wa,
                                input logic wen, input logic ifid, input logic idexe,
                                input logic bub, input logic busy, input logic chkf,
                                input logic [1:0] fa, input logic [1:0] fb, input int stall);
        vec_t v;
        v.vld = vld; v.op = op; v.ra1 = ra1; v.ra2 = ra2; v.use2 = use2;
        v.wa = wa; v.wen = wen; v.e_ifid = ifid; v.e_idexe = idexe; v.e_bub = bub;
        v.e_busy = busy; v.chk_fwd = chkf; v.e_fa = fa; v.e_fb = fb; v.e_stall = stall;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic vld, input logic [2:0] op, input logic [4:0] ra1,
                         input logic [4:0] ra2, input logic use2, input logic [4:0] wa,
                         input logic wen);
        bus.id_valid   = vld;
        bus.id_opcode  = op;
        bus.id_raddr1  = ra1;
        bus.id_raddr2  = ra2;
        bus.id_use_rs2 = use2;
        bus.id_waddr   = wa;
        bus.id_wen     = wen;
    endtask

    task automatic check_ctrl(input string tag, input int idx, input logic ifid,
                              input logic idexe, input logic bub, input logic busy);
        check({tag, ".ifid_hold"},    idx, 16'(bus.ifid_hold),    16'(ifid));
        check({tag, ".idexe_hold"},   idx, 16'(bus.idexe_hold),   16'(idexe));
        check({tag, ".idexe_bubble"}, idx, 16'(bus.idexe_bubble), 16'(bub));
        check({tag, ".exe_busy"},     idx, 16'(bus.exe_busy),     16'(busy));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // ADD r3 -> ADD r4<-r3: forward from EX/MEM
        vecs[0]  = mk(1, ADD, 1, 2, 1, 3, 1,  0,0,0,0, 1, 2'b00, 2'b00, 0);
        vecs[1]  = mk(1, ADD, 3, 1, 1, 4, 1,  0,0,0,0, 1, 2'b00, 2'b00, 0);
        vecs[2]  = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 1, 2'b01, 2'b00, 0);
        vecs[3]  = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 0, 2'b00, 2'b00, 0);
        // LD r5 -> ADD r6<-r5+r2: one stall, then MEM/WB forward
        vecs[4]  = mk(1, LD,  1, 0, 0, 5, 1,  0,0,0,0, 0, 2'b00, 2'b00, 0);
        vecs[5]  = mk(1, ADD, 5, 2, 1, 6, 1,  1,0,1,0, 1, 2'b00, 2'b00, 0);
        vecs[6]  = mk(1, ADD, 5, 2, 1, 6, 1,  0,0,0,0, 0, 2'b00, 2'b00, 1);
        vecs[7]  = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 1, 2'b10, 2'b00, 1);
        // LD r2 -> I-type reading r5, raddr2=r2 unused: no stall
        vecs[8]  = mk(1, LD,  1, 0, 0, 2, 1,  0,0,0,0, 0, 2'b00, 2'b00, 1);
        vecs[9]  = mk(1, ADDI,5, 2, 0, 8, 1,  0,0,0,0, 1, 2'b00, 2'b00, 1);
        vecs[10] = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 1, 2'b00, 2'b00, 1);
        // writes to r0 then reads of r0
        vecs[11] = mk(1, ADD, 1, 2, 1, 0, 1,  0,0,0,0, 0, 2'b00, 2'b00, 1);
        vecs[12] = mk(1, ADD, 0, 0, 1, 9, 1,  0,0,0,0, 1, 2'b00, 2'b00, 1);
        vecs[13] = mk(1, LD,  1, 0, 0, 0, 1,  0,0,0,0, 1, 2'b00, 2'b00, 1);
        vecs[14] = mk(1, ADD, 0, 0, 1,10, 1,  0,0,0,0, 1, 2'b00, 2'b00, 1);
        vecs[15] = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 1, 2'b00, 2'b00, 1);
        // MUL r7 -> ADD reading r7: two busy cycles, EX/MEM forward
        vecs[16] = mk(1, MUL, 1, 2, 1, 7, 1,  0,0,0,0, 0, 2'b00, 2'b00, 1);
        vecs[17] = mk(1, ADD, 7, 1, 1,11, 1,  1,1,0,1, 1, 2'b00, 2'b00, 1);
        vecs[18] = mk(1, ADD, 7, 1, 1,11, 1,  1,1,0,1, 0, 2'b00, 2'b00, 2);
        vecs[19] = mk(1, ADD, 7, 1, 1,11, 1,  0,0,0,0, 0, 2'b00, 2'b00, 3);
        vecs[20] = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 1, 2'b01, 2'b00, 3);
        // back-to-back MUL re-enters busy from the cnt==1 slot
        vecs[21] = mk(1, MUL, 1, 2, 1,12, 1,  0,0,0,0, 0, 2'b00, 2'b00, 3);
        vecs[22] = mk(1, MUL,12, 1, 1,13, 1,  1,1,0,1, 0, 2'b00, 2'b00, 3);
        vecs[23] = mk(1, MUL,12, 1, 1,13, 1,  1,1,0,1, 0, 2'b00, 2'b00, 4);
        vecs[24] = mk(1, MUL,12, 1, 1,13, 1,  0,0,0,0, 0, 2'b00, 2'b00, 5);
        vecs[25] = mk(0, ADD, 0, 0, 0, 0, 0,  1,1,0,1, 1, 2'b01, 2'b00, 5);
        vecs[26] = mk(0, ADD, 0, 0, 0, 0, 0,  1,1,0,1, 0, 2'b00, 2'b00, 6);
        vecs[27] = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 0, 2'b00, 2'b00, 7);
        vecs[28] = mk(0, ADD, 0, 0, 0, 0, 0,  0,0,1,0, 0, 2'b00, 2'b00, 7);

        rst = 1'b1;
        drive(0, ADD, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_ctrl("reset", -1, 0, 0, 1, 0);
        check("reset.fwd_a",     -1, 16'(bus.fwd_a), 16'h0);
        check("reset.fwd_b",     -1, 16'(bus.fwd_b), 16'h0);
        check("reset.stall_cnt", -1, bus.stall_cnt,  16'h0);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].vld, vecs[i].op, vecs[i].ra1, vecs[i].ra2, vecs[i].use2,
                  vecs[i].wa, vecs[i].wen);
            @(negedge clk);
            check_ctrl("vec", i, vecs[i].e_ifid, vecs[i].e_idexe, vecs[i].e_bub, vecs[i].e_busy);
            check("vec.stall_cnt", i, bus.stall_cnt, 16'(vecs[i].e_stall));
            if (vecs[i].chk_fwd) begin
                check("vec.fwd_a", i, 16'(bus.fwd_a), 16'(vecs[i].e_fa));
                check("vec.fwd_b", i, 16'(bus.fwd_b), 16'(vecs[i].e_fb));
            end
        end

        // Reset in the second MBUSY cycle
        @(posedge clk); #1;
        drive(1, MUL, 1, 2, 1, 14, 1);
        @(negedge clk);
        check_ctrl("rstmul.issue", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, ADD, 14, 1, 1, 15, 1);
        @(negedge clk);
        check_ctrl("rstmul.busy1", 1, 1, 1, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_ctrl("rstmul.busy2", 2, 1, 1, 0, 1);
        check("rstmul.stall_pre", 2, bus.stall_cnt, 16'd8);
        #1;
        rst = 1'b1;
        drive(0, ADD, 0, 0, 0, 0, 0);
        #1;
        check_ctrl("rstmul.reset", 3, 0, 0, 1, 0);
        check("rstmul.stall_cnt", 3, bus.stall_cnt,  16'h0);
        check("rstmul.fwd_a",     3, 16'(bus.fwd_a), 16'h0);
        check("rstmul.fwd_b",     3, 16'(bus.fwd_b), 16'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1, ADD, 14, 1, 1, 15, 1);
        @(negedge clk);
        check_ctrl("rstmul.after", 4, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, ADD, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rstmul.fwd_a_clr", 5, 16'(bus.fwd_a), 16'h0);
        check("rstmul.stall_post", 5, bus.stall_cnt, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
